instruction_loader: RTL

Byte-stream program loader that fills the instruction store at boot. It accepts a length-prefixed big-endian byte stream over a valid/ready handshake, assembles 16-bit instruction words, and drives the write port of the writable instruction memory at consecutive addresses. It sits between the host/test interface and the instruction memory, and holds the processor off via `busy` until the image is loaded.

---
 rtl/instruction_loader_pkg.sv | 16 +
 rtl/instruction_loader_xor_checksum.sv | 26 ++
 rtl/instruction_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared types and widths for the instruction loader and its checksum helper.
package instruction_loader_pkg;
  localparam int STREAM_BYTE_WIDTH = 8;
  localparam int WORD_WIDTH        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_e;
endpackage

// File: rtl/instruction_loader_xor_checksum.sv
// Running XOR over stream bytes; cleared at the start of each load.
module xor_checksum
  import instruction_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear_i,
  input  logic                         enable_i,
  input  logic [STREAM_BYTE_WIDTH-1:0] byte_i,
  output logic [STREAM_BYTE_WIDTH-1:0] acc_o
);
  logic [STREAM_BYTE_WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear_i)       acc_d = '0;
    else if (enable_i) acc_d = acc_q ^ byte_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/instruction_loader.sv
// Boot-time loader: length-prefixed big-endian byte stream -> instruction memory writes.
// Optional trailing XOR checksum byte when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int                    DEPTH        = 1024,
  parameter logic [WORD_WIDTH-1:0] BASE_ADDRESS = 16'h0000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         byte_valid,
  input  logic [STREAM_BYTE_WIDTH-1:0] byte_data,
  output logic                         byte_ready,
  output logic                         mem_write_enable,
  output logic [WORD_WIDTH-1:0]        mem_address,
  output logic [WORD_WIDTH-1:0]        mem_write_data,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);
  localparam logic [WORD_WIDTH:0] DEPTH_W = (WORD_WIDTH+1)'(DEPTH);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam state_e END_ST = ST_CHECK;
`else
  localparam state_e END_ST = ST_DONE;
`endif

  state_e                       state_q, state_d;
  logic [WORD_WIDTH-1:0]        addr_q, addr_d;
  logic [WORD_WIDTH-1:0]        data_q, data_d;
  logic                         error_q, error_d;
  logic [WORD_WIDTH-1:0]        count_q, count_d;
  logic [STREAM_BYTE_WIDTH-1:0] len_hi_q, len_hi_d;
  logic [STREAM_BYTE_WIDTH-1:0] hi_q, hi_d;
  logic [WORD_WIDTH-1:0]        len_n;
  logic                         xfer;
  logic                         idle_or_done;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign xfer         = byte_valid && byte_ready;
  assign len_n        = {len_hi_q, byte_data};

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [STREAM_BYTE_WIDTH-1:0] chk_acc;
  logic                         chk_en;

  // The checksum byte itself is excluded from the running XOR.
  assign chk_en = xfer && (state_q != ST_CHECK);

  xor_checksum u_xor_checksum (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (start && idle_or_done),
    .enable_i (chk_en),
    .byte_i   (byte_data),
    .acc_o    (chk_acc)
  );
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    error_d  = error_q;
    count_d  = count_q;
    len_hi_d = len_hi_q;
    hi_d     = hi_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LEN_HI;
          error_d = 1'b0;
          addr_d  = BASE_ADDRESS;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_hi_d = byte_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          if (len_n == '0) begin
            state_d = END_ST;
          end else if ({1'b0, len_n} > DEPTH_W) begin
            // Oversized image: reject outright, no checksum byte is taken.
            state_d = ST_DONE;
            error_d = 1'b1;
          end else begin
            count_d = len_n;
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (xfer) begin
          hi_d    = byte_data;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          data_d  = {hi_q, byte_data};
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q - 1'b1;
        state_d = (count_q == 16'd1) ? END_ST : ST_DATA_HI;
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          error_d = (byte_data != chk_acc);
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_ADDRESS;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    count_q  <= count_d;
    len_hi_q <= len_hi_d;
    hi_q     <= hi_d;
  end

  assign byte_ready       = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                            (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                            (state_q == ST_CHECK);
  assign mem_write_enable = (state_q == ST_WRITE);
  assign mem_address      = addr_q;
  assign mem_write_data   = data_q;
  assign busy             = !idle_or_done;
  assign done             = (state_q == ST_DONE);
  assign error            = error_q;
endmodule
